// File: rtl/dcache_mem_pkg.sv
// Shared types for the dcache-to-memory arbiter: channel FSM encoding and
// the lane-index width helper.
package dcache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    RELAY
  } channel_state_t;

  function automatic int unsigned lane_idx_bits(input int unsigned n);
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage

// File: rtl/dcache_mem_channel.sv
// One external memory channel: claims a consumer lane round-robin, runs the
// memory request, then relays the ready back until the lane drops its valid.
module dcache_mem_channel
  import dcache_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           avail,
  input  logic [NUM_CONSUMERS-1:0]           lane_read_valid,
  input  logic [NUM_CONSUMERS-1:0]           lane_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] lane_read_address,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] lane_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] lane_write_data,
  output logic [NUM_CONSUMERS-1:0]           claim_now,
  output logic [NUM_CONSUMERS-1:0]           release_now,
  output logic [NUM_CONSUMERS-1:0]           read_done,
  output logic [NUM_CONSUMERS-1:0]           read_ready,
  output logic [NUM_CONSUMERS-1:0]           write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int unsigned IDX_BITS = lane_idx_bits(NUM_CONSUMERS);
  localparam int unsigned LAST     = NUM_CONSUMERS - 1;

  channel_state_t state, next_state;

  logic [IDX_BITS-1:0]      id_q, rr_q, pick, next_rr, scan_idx;
  logic                     is_read_q, found, pick_read, relay_exit;
  logic [ADDR_BITS-1:0]     addr_q;
  logic [DATA_BITS-1:0]     wdata_q;
  logic [NUM_CONSUMERS-1:0] id_mask, pick_mask;
  int unsigned              scan_lane;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Scan starts at the rr pointer and wraps; avail already excludes lanes
  // owned by other channels, including ones claimed earlier this cycle.
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    scan_lane  = 0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      scan_lane = 32'(rr_q) + k;
      if (scan_lane >= NUM_CONSUMERS) begin
        scan_lane = scan_lane - NUM_CONSUMERS;
      end
      scan_idx = IDX_BITS'(scan_lane);
      if (!found && avail[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
    pick_read  = lane_read_valid[pick];
    relay_exit = is_read_q ? !lane_read_valid[id_q] : !lane_write_valid[id_q];
    next_rr    = (id_q == IDX_BITS'(LAST)) ? '0 : id_q + 1'b1;

    next_state = state;
    case (state)
      IDLE:          if (found) next_state = pick_read ? READ_WAITING : WRITE_WAITING;
      READ_WAITING:  if (mem_read_ready) next_state = RELAY;
      WRITE_WAITING: if (mem_write_ready) next_state = RELAY;
      RELAY:         if (relay_exit) next_state = IDLE;
      default:       next_state = IDLE;
    endcase
  end

  always_comb begin
    id_mask         = '0;
    id_mask[id_q]   = 1'b1;
    pick_mask       = '0;
    pick_mask[pick] = 1'b1;
    claim_now       = (state == IDLE && found) ? pick_mask : '0;
    release_now     = (state == RELAY && relay_exit) ? id_mask : '0;
    read_done       = (state == READ_WAITING && mem_read_ready) ? id_mask : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_q            <= '0;
      rr_q            <= '0;
      is_read_q       <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      mem_read_valid  <= 1'b0;
      mem_write_valid <= 1'b0;
      read_ready      <= '0;
      write_ready     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id_q            <= pick;
            is_read_q       <= pick_read;
            mem_read_valid  <= pick_read;
            mem_write_valid <= !pick_read;
            if (pick_read) begin
              addr_q <= lane_read_address[32'(pick)*ADDR_BITS +: ADDR_BITS];
            end else begin
              addr_q  <= lane_write_address[32'(pick)*ADDR_BITS +: ADDR_BITS];
              wdata_q <= lane_write_data[32'(pick)*DATA_BITS +: DATA_BITS];
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            read_ready     <= id_mask;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid <= 1'b0;
            write_ready     <= id_mask;
          end
        end
        RELAY: begin
          if (relay_exit) begin
            read_ready  <= '0;
            write_ready <= '0;
            rr_q        <= next_rr;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: rtl/dcache_mem_arbiter.sv
// Multiplexes dcache controller request lanes onto NUM_CHANNELS memory
// channels and routes ready/data back to the lane that issued each request.
module dcache_mem_arbiter
  import dcache_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  logic [NUM_CONSUMERS-1:0] lane_req, claim_q, release_all;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] release_ch, read_done_ch;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] read_ready_ch, write_ready_ch;

  assign lane_req = consumer_read_valid | consumer_write_valid;

  // Claim mask ripples through the channels in index order so a lower
  // channel's same-cycle claim hides that lane from every higher channel.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] mask_in, mask_out, claim_now;

    if (c == 0) begin : g_head
      assign mask_in = claim_q;
    end else begin : g_tail
      assign mask_in = g_ch[c-1].mask_out;
    end
    assign mask_out = mask_in | claim_now;

    dcache_mem_channel #(
      .ADDR_BITS     (ADDR_BITS),
      .DATA_BITS     (DATA_BITS),
      .NUM_CONSUMERS (NUM_CONSUMERS)
    ) u_channel (
      .clk                (clk),
      .reset              (reset),
      .avail              (lane_req & ~mask_in),
      .lane_read_valid    (consumer_read_valid),
      .lane_write_valid   (consumer_write_valid),
      .lane_read_address  (consumer_read_address),
      .lane_write_address (consumer_write_address),
      .lane_write_data    (consumer_write_data),
      .claim_now          (claim_now),
      .release_now        (release_ch[c]),
      .read_done          (read_done_ch[c]),
      .read_ready         (read_ready_ch[c]),
      .write_ready        (write_ready_ch[c]),
      .mem_read_valid     (mem_read_valid[c]),
      .mem_read_address   (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_read_ready     (mem_read_ready[c]),
      .mem_write_valid    (mem_write_valid[c]),
      .mem_write_address  (mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data     (mem_write_data[c*DATA_BITS +: DATA_BITS]),
      .mem_write_ready    (mem_write_ready[c])
    );
  end

  always_comb begin
    release_all          = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      release_all          = release_all | release_ch[c];
      consumer_read_ready  = consumer_read_ready | read_ready_ch[c];
      consumer_write_ready = consumer_write_ready | write_ready_ch[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      claim_q <= '0;
    end else begin
      claim_q <= g_ch[NUM_CHANNELS-1].mask_out & ~release_all;
    end
  end

  // Read data is kept per lane so it survives after ready falls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      consumer_read_data <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
          if (read_done_ch[c][i]) begin
            consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter with 4 lanes and 2 channels.
module tb_dcache_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  consumer_read_valid;
  logic [31:0] consumer_read_address;
  logic [3:0]  consumer_read_ready;
  logic [31:0] consumer_read_data;
  logic [3:0]  consumer_write_valid;
  logic [31:0] consumer_write_address;
  logic [31:0] consumer_write_data;
  logic [3:0]  consumer_write_ready;
  logic [1:0]  mem_read_valid;
  logic [15:0] mem_read_address;
  logic [1:0]  mem_read_ready;
  logic [15:0] mem_read_data;
  logic [1:0]  mem_write_valid;
  logic [15:0] mem_write_address;
  logic [15:0] mem_write_data;
  logic [1:0]  mem_write_ready;

  int checks = 0;
  int errors = 0;

  dcache_mem_arbiter #(
    .ADDR_BITS     (8),
    .DATA_BITS     (8),
    .NUM_CONSUMERS (4),
    .NUM_CHANNELS  (2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    mem_read_ready         = '0;
    mem_read_data          = '0;
    mem_write_ready        = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_rdy"}, 32'(consumer_read_ready), 32'h0);
    check({tag, "_rd_data"}, consumer_read_data, 32'h0);
    check({tag, "_wr_rdy"}, 32'(consumer_write_ready), 32'h0);
    check({tag, "_mem_rv"}, 32'(mem_read_valid), 32'h0);
    check({tag, "_mem_ra"}, 32'(mem_read_address), 32'h0);
    check({tag, "_mem_wv"}, 32'(mem_write_valid), 32'h0);
    check({tag, "_mem_wa"}, 32'(mem_write_address), 32'h0);
    check({tag, "_mem_wd"}, 32'(mem_write_data), 32'h0);
  endtask

  initial begin
    logic [1:0] lane;

    // 1: reset with random inputs, then idle
    reset                  = 1'b0;
    consumer_read_valid    = 4'($urandom);
    consumer_read_address  = $urandom;
    consumer_write_valid   = 4'($urandom);
    consumer_write_address = $urandom;
    consumer_write_data    = $urandom;
    mem_read_ready         = 2'($urandom);
    mem_read_data          = 16'($urandom);
    mem_write_ready        = 2'($urandom);
    tick();
    tick();
    check_all_zero("rst");
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("idle");
    mem_read_ready  = 2'b11;
    mem_write_ready = 2'b11;
    mem_read_data   = 16'hFFFF;
    tick();
    check_all_zero("stray_mem_rdy");
    clear_inputs();

    // 2: single read on lane 1
    apply_reset();
    consumer_read_valid          = 4'b0010;
    consumer_read_address[15:8]  = 8'h3C;
    tick();
    check("t2_mem_rv", 32'(mem_read_valid), 32'h1);
    check("t2_mem_ra", 32'(mem_read_address[7:0]), 32'h3C);
    tick();
    tick();
    check("t2_hold_rv", 32'(mem_read_valid), 32'h1);
    check("t2_hold_rdy", 32'(consumer_read_ready), 32'h0);
    mem_read_ready = 2'b01;
    mem_read_data  = 16'h00A5;
    tick();
    mem_read_ready = 2'b00;
    check("t2_rdy", 32'(consumer_read_ready), 32'h2);
    check("t2_data", 32'(consumer_read_data[15:8]), 32'hA5);
    check("t2_rv_drop", 32'(mem_read_valid), 32'h0);
    tick();
    check("t2_rdy_held", 32'(consumer_read_ready), 32'h2);
    consumer_read_valid = 4'b0000;
    tick();
    check("t2_rdy_clr", 32'(consumer_read_ready), 32'h0);
    check("t2_data_kept", 32'(consumer_read_data[15:8]), 32'hA5);

    // 3: three simultaneous reads, two channels
    apply_reset();
    consumer_read_valid   = 4'b0111;
    consumer_read_address = 32'h0042_4140;
    tick();
    check("t3_rv", 32'(mem_read_valid), 32'h3);
    check("t3_ch0_addr", 32'(mem_read_address[7:0]), 32'h40);
    check("t3_ch1_addr", 32'(mem_read_address[15:8]), 32'h41);
    mem_read_ready = 2'b11;
    mem_read_data  = 16'h9190;
    tick();
    mem_read_ready = 2'b00;
    check("t3_rdy", 32'(consumer_read_ready), 32'h3);
    check("t3_data01", 32'(consumer_read_data[15:0]), 32'h9190);
    check("t3_rv_idle", 32'(mem_read_valid), 32'h0);
    consumer_read_valid = 4'b0110;
    tick();
    check("t3_rdy_k", 32'(consumer_read_ready), 32'h2);
    check("t3_lane2_waits", 32'(mem_read_valid), 32'h0);
    tick();
    check("t3_lane2_rv", 32'(mem_read_valid), 32'h1);
    check("t3_lane2_addr", 32'(mem_read_address[7:0]), 32'h42);
    mem_read_ready = 2'b01;
    mem_read_data  = 16'h0092;
    tick();
    mem_read_ready = 2'b00;
    check("t3_rdy2", 32'(consumer_read_ready), 32'h6);
    check("t3_data", consumer_read_data, 32'h0092_9190);
    consumer_read_valid = 4'b0000;
    tick();
    check("t3_rdy_clr", 32'(consumer_read_ready), 32'h0);
    check("t3_rv_clr", 32'(mem_read_valid), 32'h0);

    // 4: write on lane 3 alongside read on lane 2
    apply_reset();
    consumer_read_valid           = 4'b0100;
    consumer_read_address[23:16]  = 8'h20;
    consumer_write_valid          = 4'b1000;
    consumer_write_address[31:24] = 8'h10;
    consumer_write_data[31:24]    = 8'h77;
    tick();
    check("t4_rv", 32'(mem_read_valid), 32'h1);
    check("t4_ra", 32'(mem_read_address[7:0]), 32'h20);
    check("t4_wv", 32'(mem_write_valid), 32'h2);
    check("t4_wa", 32'(mem_write_address[15:8]), 32'h10);
    check("t4_wd", 32'(mem_write_data[15:8]), 32'h77);
    mem_write_ready = 2'b10;
    tick();
    mem_write_ready = 2'b00;
    check("t4_wr_rdy", 32'(consumer_write_ready), 32'h8);
    check("t4_wv_drop", 32'(mem_write_valid), 32'h0);
    check("t4_rd_rdy0", 32'(consumer_read_ready), 32'h0);
    mem_read_ready = 2'b01;
    mem_read_data  = 16'h005A;
    tick();
    mem_read_ready = 2'b00;
    check("t4_rd_rdy", 32'(consumer_read_ready), 32'h4);
    check("t4_rd_data", 32'(consumer_read_data[23:16]), 32'h5A);
    check("t4_wr_rdy_held", 32'(consumer_write_ready), 32'h8);
    consumer_read_valid  = 4'b0000;
    consumer_write_valid = 4'b0000;
    tick();
    check("t4_rd_clr", 32'(consumer_read_ready), 32'h0);
    check("t4_wr_clr", 32'(consumer_write_ready), 32'h0);

    // 5: ch1 stalled on lane 1; ch0 alternates lanes 0 and 2
    apply_reset();
    consumer_read_valid   = 4'b0111;
    consumer_read_address = 32'h0052_5150;
    tick();
    check("t5_rv", 32'(mem_read_valid), 32'h3);
    for (int r = 0; r < 4; r++) begin
      lane = (r % 2 == 1) ? 2'd2 : 2'd0;
      check("t5_ch0_addr", 32'(mem_read_address[7:0]), 32'h50 + 32'(lane));
      check("t5_ch1_busy", {31'b0, mem_read_valid[1]}, 32'h1);
      mem_read_ready = 2'b01;
      mem_read_data  = 16'h00C0 | 16'(lane);
      tick();
      mem_read_ready = 2'b00;
      check("t5_rdy", 32'(consumer_read_ready), 32'h1 << lane);
      check("t5_data", 32'(consumer_read_data[8*lane +: 8]), 32'hC0 + 32'(lane));
      consumer_read_valid[lane] = 1'b0;
      tick();
      check("t5_rdy_clr", 32'(consumer_read_ready), 32'h0);
      consumer_read_valid[lane] = 1'b1;
      tick();
    end

    // 6: reset mid READ_WAITING, then a fresh request
    check("t6_pre_rv", 32'(mem_read_valid), 32'h3);
    reset = 1'b0;
    clear_inputs();
    tick();
    check_all_zero("t6_rst");
    reset = 1'b1;
    tick();
    consumer_read_valid         = 4'b0001;
    consumer_read_address[7:0]  = 8'h66;
    tick();
    check("t6_rv", 32'(mem_read_valid), 32'h1);
    check("t6_ra", 32'(mem_read_address[7:0]), 32'h66);
    mem_read_ready = 2'b01;
    mem_read_data  = 16'h0099;
    tick();
    mem_read_ready = 2'b00;
    check("t6_rdy", 32'(consumer_read_ready), 32'h1);
    check("t6_data", 32'(consumer_read_data[7:0]), 32'h99);
    consumer_read_valid = 4'b0000;
    tick();
    check("t6_rdy_clr", 32'(consumer_read_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_mem_arbiter.md
Name: dcache_mem_arbiter

Overview:
Sits directly downstream of dcache. It takes the per-consumer controller_read_*/controller_write_* request lanes that dcache drives on misses and write-throughs, and multiplexes them onto NUM_CHANNELS external memory channels. Each channel runs its own request FSM, and channels claim consumer lanes round-robin. Data and ready responses are returned to the originating lane using a valid/ready hold-until-acknowledged handshake.

Parameters:
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data width
NUM_CONSUMERS, 8, request lanes from dcache (matches dcache NUM_CONSUMERS)
NUM_CHANNELS, 8, external memory channels; 1..NUM_CONSUMERS, larger values legal but extra channels stay idle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
consumer_read_valid  in  NUM_CONSUMERS  per-lane read request (dcache controller_read_valid)
consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  read address per lane
consumer_read_ready  out  NUM_CONSUMERS  read complete, data valid
consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  returned read data
consumer_write_valid  in  NUM_CONSUMERS  per-lane write request
consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write address
consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data
consumer_write_ready  out  NUM_CONSUMERS  write accepted by memory
mem_read_valid  out  NUM_CHANNELS  channel read request
mem_read_address  out  NUM_CHANNELS x ADDR_BITS  channel read address
mem_read_ready  in  NUM_CHANNELS  memory read done, data valid this cycle
mem_read_data  in  NUM_CHANNELS x DATA_BITS  memory read data
mem_write_valid  out  NUM_CHANNELS  channel write request
mem_write_address  out  NUM_CHANNELS x ADDR_BITS  channel write address
mem_write_data  out  NUM_CHANNELS x DATA_BITS  channel write data
mem_write_ready  in  NUM_CHANNELS  memory write done

Behaviour:
- Reset (reset==0 sampled at posedge): all channels go to IDLE. Every output is 0, the claim mask is cleared and every round-robin pointer is 0. Reset mid-transaction abandons it and the memory sees valid drop the next cycle.
- Channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, RELAY. All outputs are registered.
- IDLE:
  - The channel scans lanes starting at its rr pointer, wrapping modulo NUM_CONSUMERS.
  - It picks the first lane with read_valid|write_valid that is not claimed by another channel.
  - Within a cycle, channel c sees claims made by channels 0..c-1 in that same cycle, so no lane is ever double-claimed.
  - If a lane has both valids, read wins; the write is served on a later claim.
  - On a claim, the channel latches lane id, address and data, sets the claim bit, and goes to READ_WAITING with mem_read_valid=1 or WRITE_WAITING with mem_write_valid=1.
  - Latency: lane valid sampled at edge N gives mem_*_valid high after edge N.
- READ_WAITING:
  - Holds mem_read_valid and mem_read_address until mem_read_ready is sampled 1 at edge M.
  - At M: mem_read_valid goes to 0, consumer_read_data[id] takes mem_read_data, consumer_read_ready[id] goes to 1, state goes to RELAY.
- WRITE_WAITING:
  - Identical to READ_WAITING, using mem_write_ready and consumer_write_ready.
- RELAY:
  - Holds ready (and read_data) until the lane's corresponding valid is sampled 0 at edge K.
  - At K: ready goes to 0, the claim bit is cleared, rr pointer becomes (id+1) mod NUM_CONSUMERS, state goes to IDLE.
  - The lane becomes claimable again from edge K+1.
- Valid dropped early while in *_WAITING: the transaction still completes; ready is high for exactly one cycle, then RELAY exits.
- consumer_read_data holds its last value after ready falls. It is cleared only by reset.
- mem_*_ready asserted while the channel is not waiting: ignored.
- Lanes not claimed by any channel see ready=0.

Decomposition:
- Package dcache_mem_pkg holds the channel_state_t enum (IDLE, READ_WAITING, WRITE_WAITING, RELAY) and a localparam/function for the lane-index width, $clog2(NUM_CONSUMERS) with a minimum of 1.
- Sub-module dcache_mem_channel holds one channel's FSM, latches and rr pointer. It takes the masked request vector and emits its claim.
- The top level builds the cascaded claim mask and the per-lane OR of channel responses, then generates NUM_CHANNELS instances.

Test Plan:
Bench instantiates NUM_CONSUMERS=4, NUM_CHANNELS=2, with 8-bit address and data.
1. Hold reset=0 for 2 cycles with all inputs random -> every output is 0. Release reset; with no requests, outputs stay 0.
2. Lane 1 raises read 0x3C; memory returns ready with 0xA5 three cycles later -> mem_read_valid[0]=1 with addr 0x3C one edge after the request. consumer_read_ready[1]=1 with data 0xA5 one edge after mem ready. Ready stays high until valid drops, then clears.
3. Lanes 0, 1 and 2 all request reads in the same cycle -> ch0 takes lane 0 and ch1 takes lane 1. Lane 2 waits until a channel's RELAY exits, then is served by that channel. No lane is double-served.
4. Lane 3 write 0x10/0x77 while lane 2 reads 0x20 -> mem_write_valid=1 with 0x10/0x77 and mem_read_valid=1 with 0x20 on separate channels. consumer_write_ready[3] rises one edge after mem_write_ready.
5. Round-robin: ch0 only (ch1 kept busy by a stalled memory), lanes 0 and 2 requesting continuously -> ch0 alternates lane 0 then lane 2 with no starvation.
6. Reset asserted while ch0 is in READ_WAITING -> mem_read_valid=0 after that edge. After release, the re-raised request is served normally.
